// File: rtl/datapath_ctrl.sv
// datapath_ctrl: Moore sequencer for the 8-bit register/ALU datapath.
// It accepts one instruction plus an immediate per start/busy/done handshake.
// It then steps through LOADA (two-step ops only), EXEC and DONE.
//
// state | meaning
// IDLE  | waiting for start; instr/imm captured on accept
// LOADA | tmp <= rd (XOR/AND/SHL only)
// EXEC  | single register writeback cycle (or idle for NOP/illegal)
// DONE  | one-cycle done pulse; err flags an illegal opcode
module datapath_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] instr,
  input  logic [7:0] imm,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] dp_in,
  output logic [1:0] sr,
  output logic [1:0] Rn,
  output logic       w,
  output logic [1:0] aluop,
  output logic       lt,
  output logic [2:0] tsel,
  output logic [2:0] bsel
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOADA = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] OP_LDI = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_MOV = 3'b100;

  state_t     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] imm_q, imm_d;

  logic [2:0] op;
  logic [1:0] rd, rs;
  logic       rsvd_unused;

  assign op          = ir_q[7:5];
  assign rd          = ir_q[4:3];
  assign rs          = ir_q[2:1];
  assign rsvd_unused = ir_q[0];
  assign dp_in       = imm_q;

  // Register index to B-operand select; index 0 selects the constant-zero operand.
  function automatic logic [2:0] onehot(input logic [1:0] x);
    case (x)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // State and captured instruction/immediate registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ir_q    <= 8'h00;
      imm_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
    end
  end

  // Next state and capture: instr/imm are only looked at on an IDLE accept.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ir_d  = instr;
          imm_d = imm;
          if (instr[7:5] == OP_XOR || instr[7:5] == OP_AND || instr[7:5] == OP_SHL)
            state_d = LOADA;
          else
            state_d = EXEC;
        end
      end
      LOADA:   state_d = EXEC;
      EXEC:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Moore control outputs decoded from state and the captured instruction.
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    err   = 1'b0;
    sr    = 2'b00;
    Rn    = 2'b00;
    w     = 1'b0;
    aluop = 2'b00;
    lt    = 1'b0;
    tsel  = 3'b000;
    bsel  = 3'b000;
    case (state_q)
      LOADA: begin
        busy = 1'b1;
        lt   = 1'b1;
        if (rd == 2'd0) begin
          tsel = 3'b010;
        end else begin
          bsel = onehot(rd);
          tsel = 3'b100;
        end
      end
      EXEC: begin
        busy = 1'b1;
        case (op)
          OP_LDI: begin
            sr = 2'b00;
            w  = 1'b1;
            Rn = rd;
          end
          OP_XOR, OP_AND: begin
            bsel  = onehot(rs);
            aluop = (op == OP_XOR) ? 2'b00 : 2'b01;
            sr    = 2'b01;
            w     = 1'b1;
            Rn    = rd;
          end
          OP_SHL: begin
            aluop = 2'b10;
            sr    = 2'b01;
            w     = 1'b1;
            Rn    = rd;
          end
          OP_MOV: begin
            bsel  = onehot(rs);
            aluop = 2'b11;
            sr    = 2'b01;
            w     = 1'b1;
            Rn    = rd;
          end
          default: ;
        endcase
      end
      DONE: begin
        done = 1'b1;
        err  = op[2] & op[1];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: expected per-cycle control vectors come from an
// instruction-level schedule model. A small datapath model turns the DUT
// controls into register values, which are pinned with hand-computed literals.
module tb_datapath_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] instr;
  logic [7:0] imm;
  logic       busy, done, err, w, lt;
  logic [7:0] dp_in;
  logic [1:0] sr, Rn, aluop;
  logic [2:0] tsel, bsel;

  datapath_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .imm(imm),
    .busy(busy), .done(done), .err(err), .dp_in(dp_in), .sr(sr), .Rn(Rn),
    .w(w), .aluop(aluop), .lt(lt), .tsel(tsel), .bsel(bsel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy, done, err, lt, w;
    logic [1:0] sr, rn, aluop;
    logic [2:0] tsel, bsel;
    logic [7:0] dp;
  } ctrl_t;

  int n_cmp = 0;
  int n_bad = 0;
  int w_cnt, lt_cnt, done_cnt;

  ctrl_t      mq[$];
  logic [7:0] m_imm = 8'h00;
  ctrl_t      snap = '0;
  logic [7:0] R[4];
  logic [7:0] tmp;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] oh(input logic [1:0] x);
    case (x)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Instruction-level schedule: list of cycle vectors an accepted instruction produces.
  function automatic ctrl_t loada_vec(input logic [1:0] rd);
    ctrl_t v = '0;
    v.busy = 1'b1;
    v.lt   = 1'b1;
    if (rd == 2'd0) v.tsel = 3'b010;
    else begin
      v.tsel = 3'b100;
      v.bsel = oh(rd);
    end
    return v;
  endfunction

  function automatic ctrl_t exec_vec(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs);
    ctrl_t v = '0;
    v.busy = 1'b1;
    if (op <= 3'd4) begin
      v.w  = 1'b1;
      v.rn = rd;
      v.sr = (op == 3'd0) ? 2'b00 : 2'b01;
    end
    case (op)
      3'd1: v.bsel = oh(rs);
      3'd2: begin v.bsel = oh(rs); v.aluop = 2'b01; end
      3'd3: v.aluop = 2'b10;
      3'd4: begin v.bsel = oh(rs); v.aluop = 2'b11; end
      default: ;
    endcase
    return v;
  endfunction

  // Schedule model: pop one cycle per edge; when idle, an asserted start enqueues a new instruction.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_imm = 8'h00;
    end else if (mq.size() > 0) begin
      void'(mq.pop_front());
    end else if (start) begin
      ctrl_t d;
      m_imm = imm;
      if (instr[7:5] >= 3'd1 && instr[7:5] <= 3'd3) mq.push_back(loada_vec(instr[4:3]));
      mq.push_back(exec_vec(instr[7:5], instr[4:3], instr[2:1]));
      d      = '0;
      d.done = 1'b1;
      d.err  = (instr[7:5] >= 3'd6);
      mq.push_back(d);
    end
  end

  // Per-cycle compare against the schedule; also snapshot controls for the datapath model.
  always @(negedge clk) begin
    ctrl_t e;
    ctrl_t a;
    e = '0;
    if (mq.size() > 0) e = mq[0];
    e.dp = m_imm;
    a = {busy, done, err, lt, w, sr, Rn, aluop, tsel, bsel, dp_in};
    check("ctrl_vec", 32'(a), 32'(e));
    snap = a;
    if (w) w_cnt++;
    if (lt) lt_cnt++;
    if (done) done_cnt++;
  end

  // Datapath model driven by the controls seen in the cycle that just ended.
  always @(posedge clk) begin
    if (!reset) begin
      logic [7:0] b, alu;
      case (snap.bsel)
        3'b001:  b = R[1];
        3'b010:  b = R[2];
        3'b100:  b = R[3];
        default: b = 8'h00;
      endcase
      case (snap.aluop)
        2'b00:   alu = tmp ^ b;
        2'b01:   alu = tmp & b;
        2'b10:   alu = {tmp[6:0], 1'b0};
        default: alu = b;
      endcase
      if (snap.w) begin
        case (snap.sr)
          2'b00:   R[snap.rn] = snap.dp;
          2'b01:   R[snap.rn] = alu;
          default: R[snap.rn] = tmp;
        endcase
      end
      if (snap.lt) begin
        case (snap.tsel)
          3'b001:  tmp = alu;
          3'b010:  tmp = R[0];
          default: tmp = b;
        endcase
      end
    end
  end

  task automatic do_instr(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                          input logic [7:0] iv, input int exp_lat);
    int lat;
    bit seen;
    @(negedge clk);
    start  = 1'b1;
    instr  = {op, rd, rs, 1'b1};
    imm    = iv;
    w_cnt  = 0;
    lt_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    instr = 8'($urandom);
    imm   = 8'($urandom);
    lat   = 1;
    seen  = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    if (!seen) check("done_timeout", 32'(0), 32'(1));
    else begin
      check("latency", 32'(lat), 32'(exp_lat));
      check("err_at_done", 32'(err), 32'(op >= 3'd6));
    end
    check("w_pulses", 32'(w_cnt), (op <= 3'd4) ? 32'(1) : 32'(0));
    check("lt_pulses", 32'(lt_cnt), (op >= 3'd1 && op <= 3'd3) ? 32'(1) : 32'(0));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    instr = 8'h00;
    imm   = 8'h00;
    tmp   = 8'h00;
    for (int i = 0; i < 4; i++) R[i] = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_outputs", 32'({busy, done, err, lt, w, sr, Rn, aluop, tsel, bsel, dp_in}), 32'(0));
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", 32'({busy, done, err, lt, w, sr, Rn, aluop, tsel, bsel, dp_in}), 32'(0));

    do_instr(3'd0, 2'd2, 2'd0, 8'hA5, 2);
    check("ldi_r2", 32'(R[2]), 32'(8'hA5));

    do_instr(3'd0, 2'd1, 2'd0, 8'h3C, 2);
    do_instr(3'd0, 2'd3, 2'd0, 8'h0F, 2);
    do_instr(3'd1, 2'd1, 2'd3, 8'h77, 3);
    check("xor_r1", 32'(R[1]), 32'(8'h33));

    do_instr(3'd0, 2'd0, 2'd0, 8'h81, 2);
    do_instr(3'd3, 2'd0, 2'd2, 8'h00, 3);
    check("shl_r0", 32'(R[0]), 32'(8'h02));

    do_instr(3'd0, 2'd2, 2'd0, 8'hFF, 2);
    do_instr(3'd2, 2'd2, 2'd0, 8'h00, 3);
    check("and_zero_r2", 32'(R[2]), 32'(8'h00));

    do_instr(3'd7, 2'd1, 2'd2, 8'hEE, 2);
    check("illegal_regs", 32'({R[0], R[1], R[2], R[3]}), 32'h0233000F);
    do_instr(3'd5, 2'd3, 2'd1, 8'h11, 2);
    check("nop_r3", 32'(R[3]), 32'(8'h0F));

    // start held high across back-to-back MOV R3 <= R1
    @(negedge clk);
    start    = 1'b1;
    instr    = {3'b100, 2'd3, 2'd1, 1'b0};
    imm      = 8'h5A;
    done_cnt = 0;
    repeat (12) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mov_accepts", 32'(done_cnt), 32'(4));
    check("mov_r3", 32'(R[3]), 32'(8'h33));

    // reset during EXEC of XOR R2 ^= R1
    @(negedge clk);
    start = 1'b1;
    instr = {3'b001, 2'd2, 2'd1, 1'b0};
    imm   = 8'h00;
    @(negedge clk);
    start = 1'b0;
    check("xor_loada_lt", 32'(lt), 32'(1));
    @(posedge clk);
    #2;
    check("exec_w_before_rst", 32'(w), 32'(1));
    reset = 1'b1;
    #1;
    check("rst_drops", 32'({w, lt, busy}), 32'(0));
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_no_write_r2", 32'(R[2]), 32'(8'h00));
    do_instr(3'd5, 2'd0, 2'd0, 8'h42, 2);
    check("post_rst_dp_in", 32'(dp_in), 32'(8'h42));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
